// File: rtl/srt2_pkg.sv
// Shared definitions for the SRT radix-2 divider: sequencer states,
// control-word bit positions and the composite words used by the datapath.
package srt2_pkg;

  // Number of quotient-digit iterations for the 8-bit datapath.
  localparam int ITER = 8;

  // Width of the datapath control word.
  localparam int C_W = 14;

  // Sequencer states.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD1   = 4'd1,
    S_LOAD2   = 4'd2,
    S_NORM    = 4'd3,
    S_CHECK   = 4'd4,
    S_COUNT   = 4'd5,
    S_CORRECT = 4'd6,
    S_RESULT  = 4'd7,
    S_UNNORM  = 4'd8,
    S_OUT_Q   = 4'd9,
    S_OUT_A   = 4'd10,
    S_DONE    = 4'd11
  } srt2_state_e;

  // Control-word bit indices.
  localparam int C_LOAD1  = 0;   // clear A, Q*, CNT2; load Q
  localparam int C_LOAD2  = 1;   // load M, compute leading zeros
  localparam int C_NORM   = 2;   // normalise divisor/dividend
  localparam int C_SHIFT  = 3;   // q = 0: shift only
  localparam int C_ADD    = 4;   // q = -1: set Q* bit, add M
  localparam int C_SUB    = 5;   // q = +1: set Q bit, subtract M
  localparam int C_CORR_A = 6;   // correction / result helper
  localparam int C_RES_A  = 7;   // result helper
  localparam int C_COUNT  = 8;   // advance datapath counter
  localparam int C_CORR_B = 9;   // correction step
  localparam int C_RES_B  = 10;  // quotient assembly
  localparam int C_UNNORM = 11;  // denormalise remainder
  localparam int C_OUT_Q  = 12;  // drive quotient out
  localparam int C_OUT_A  = 13;  // drive remainder out

  // Composite control words.
  localparam logic [C_W-1:0] C_NONE    = 14'h0000;
  localparam logic [C_W-1:0] C_CORRECT = 14'h0240;
  localparam logic [C_W-1:0] C_RESULT  = 14'h04C0;

  // One-hot control word with only bit idx set.
  function automatic logic [C_W-1:0] c_bit(input int idx);
    return 14'd1 << idx;
  endfunction

endpackage

// File: rtl/srt2_control_unit_qsel.sv
// SRT radix-2 quotient-digit selection: maps the partial-remainder top
// bits A[8:6] to a one-hot {subtract, add, shift} command.
module srt2_control_unit_qsel
  import srt2_pkg::*;
(
  input  logic [2:0] ctrl_bits,
  output logic [2:0] q_sel     // {c[5], c[4], c[3]}
);

  // Digit select: remainder near zero shifts, positive subtracts, negative adds.
  always_comb begin
    q_sel = 3'b001;
    case (ctrl_bits)
      3'b000, 3'b111:         q_sel = 3'b001;  // q = 0
      3'b001, 3'b010, 3'b011: q_sel = 3'b100;  // q = +1
      3'b100, 3'b101, 3'b110: q_sel = 3'b010;  // q = -1
      default:                q_sel = 3'b001;
    endcase
  end

endmodule

// File: rtl/srt2_control_unit.sv
// Sequencer for the 8-bit SRT radix-2 divider. Steps the datapath through
// load, normalise, ITER digit iterations, correction, result assembly,
// denormalise and output; the control word is Moore-decoded from state.
module srt2_control_unit #(
  parameter int ITER = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [2:0]  ctrl_bits,
  input  logic        m7,
  input  logic        cnt1,
  input  logic [2:0]  cnt2,
  output logic [13:0] c,
  output logic        busy,
  output logic        done
);

  import srt2_pkg::*;

  // cnt2 is sampled before its increment, so the last pass sees ITER-1.
  localparam logic [2:0] CNT2_LAST = 3'(ITER - 1);

  srt2_state_e state_q, state_d;
  logic [2:0]  q_sel_s;

  srt2_control_unit_qsel u_qsel (
    .ctrl_bits (ctrl_bits),
    .q_sel     (q_sel_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD1; else state_d = S_IDLE;
      S_LOAD1:   state_d = S_LOAD2;
      S_LOAD2:   if (m7) state_d = S_CHECK; else state_d = S_NORM;
      S_NORM:    state_d = S_CHECK;
      S_CHECK:   state_d = S_COUNT;
      S_COUNT: begin
        if (cnt2 != CNT2_LAST) begin
          state_d = S_CHECK;
        end else if (ctrl_bits[2]) begin
          state_d = S_CORRECT;      // negative final remainder needs a fix-up
        end else begin
          state_d = S_RESULT;
        end
      end
      S_CORRECT: state_d = S_RESULT;
      S_RESULT:  if (cnt1) state_d = S_UNNORM; else state_d = S_OUT_Q;
      S_UNNORM:  state_d = S_OUT_Q;
      S_OUT_Q:   state_d = S_OUT_A;
      S_OUT_A:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode: control word, busy and done from the registered state.
  always_comb begin
    c    = C_NONE;
    busy = 1'b0;
    done = 1'b0;
    if (state_q != S_IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
    case (state_q)
      S_IDLE:    c = C_NONE;
      S_LOAD1:   c = c_bit(C_LOAD1);
      S_LOAD2:   c = c_bit(C_LOAD2);
      S_NORM:    c = c_bit(C_NORM);
      S_CHECK:   c = ({C_W{q_sel_s[0]}} & c_bit(C_SHIFT))
                   | ({C_W{q_sel_s[1]}} & c_bit(C_ADD))
                   | ({C_W{q_sel_s[2]}} & c_bit(C_SUB));
      S_COUNT:   c = c_bit(C_COUNT);
      S_CORRECT: c = C_CORRECT;
      S_RESULT:  c = C_RESULT;
      S_UNNORM:  c = c_bit(C_UNNORM);
      S_OUT_Q:   c = c_bit(C_OUT_Q);
      S_OUT_A:   c = c_bit(C_OUT_A);
      S_DONE: begin
        c    = C_NONE;
        done = 1'b1;
      end
      default:   c = C_NONE;
    endcase
  end

endmodule

// File: tb/tb_srt2_control_unit.sv
// Self-checking bench for srt2_control_unit. A behavioural model builds the
// expected per-cycle control-word trace from the algorithm's step list; the
// bench plays the datapath (ctrl_bits, cnt2) and compares cycle by cycle.
module tb_srt2_control_unit;

  logic        clk = 1'b0;
  logic        rst_b, start, m7, cnt1;
  logic [2:0]  ctrl_bits, cnt2;
  logic [13:0] c;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  localparam int MAXL = 40;
  logic [13:0] exp_c [MAXL];
  logic        exp_busy [MAXL];
  logic        exp_done [MAXL];
  logic [2:0]  in_ctrl [MAXL];
  logic [2:0]  in_cnt2 [MAXL];
  logic [13:0] obs_c [MAXL];
  logic        obs_busy [MAXL];
  logic        obs_done [MAXL];
  int          len;
  int          done_idx;

  always #5 clk = ~clk;

  srt2_control_unit #(.ITER(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .ctrl_bits (ctrl_bits),
    .m7        (m7),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .c         (c),
    .busy      (busy),
    .done      (done)
  );

  // SRT digit rule on the signed 3-bit remainder estimate.
  function automatic logic [13:0] digit_word(input logic [2:0] cb);
    int v;
    v = int'($signed(cb));
    if (v == 0 || v == -1) return 14'h0008;
    else if (v > 0)        return 14'h0020;
    else                   return 14'h0010;
  endfunction

  task automatic push(input logic [13:0] w, input logic [2:0] cb, input logic [2:0] cn,
                      input logic b, input logic d);
    len = len + 1;
    exp_c[len] = w; in_ctrl[len] = cb; in_cnt2[len] = cn;
    exp_busy[len] = b; exp_done[len] = d;
  endtask

  // Expected trace: one entry per cycle after the start edge.
  // mode 0: ctrl_bits all zero; 1: random; 2: fixed digit pattern.
  task automatic build_model(input logic m7v, input logic cnt1v, input int mode,
                             input logic corr, input logic b2b);
    logic [2:0] cb;
    logic [2:0] cnt;
    logic [2:0] pat [4];
    pat[0] = 3'b010; pat[1] = 3'b101; pat[2] = 3'b111; pat[3] = 3'b000;
    len = 0;
    cnt = 3'd0;
    push(14'h0001, 3'($urandom), 3'($urandom), 1'b1, 1'b0);
    push(14'h0002, 3'($urandom), cnt, 1'b1, 1'b0);
    if (!m7v) push(14'h0004, 3'($urandom), cnt, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (mode == 0)      cb = 3'b000;
      else if (mode == 2) cb = pat[k % 4];
      else                cb = 3'($urandom);
      push(digit_word(cb), cb, cnt, 1'b1, 1'b0);
      cb = (mode == 0) ? 3'b000 : 3'($urandom);
      if (k == 7 && mode != 0) cb[2] = corr;
      push(14'h0100, cb, cnt, 1'b1, 1'b0);
      cnt = cnt + 3'd1;
    end
    if (mode != 0 && corr) push(14'h0240, 3'($urandom), cnt, 1'b1, 1'b0);
    push(14'h04C0, 3'($urandom), cnt, 1'b1, 1'b0);
    if (cnt1v) push(14'h0800, 3'($urandom), cnt, 1'b1, 1'b0);
    push(14'h1000, 3'($urandom), cnt, 1'b1, 1'b0);
    push(14'h2000, 3'($urandom), cnt, 1'b1, 1'b0);
    push(14'h0000, 3'($urandom), cnt, 1'b1, 1'b1);
    done_idx = len;
    if (b2b) begin
      push(14'h0000, 3'($urandom), cnt, 1'b0, 1'b0);
      push(14'h0001, 3'($urandom), cnt, 1'b1, 1'b0);
      push(14'h0002, 3'($urandom), 3'd0, 1'b1, 1'b0);
    end else begin
      for (int k = 0; k < 3; k++) push(14'h0000, 3'($urandom), 3'($urandom), 1'b0, 1'b0);
    end
  endtask

  // Play one division: start in cycle 0, then drive/observe cycles 1..len.
  task automatic run_trace(input logic m7v, input logic cnt1v, input int sp_a,
                           input int sp_b, input int rst_cycle);
    m7 = m7v; cnt1 = cnt1v;
    @(posedge clk); #1;
    start = 1'b1; ctrl_bits = 3'($urandom); cnt2 = 3'($urandom);
    for (int i = 1; i <= len; i++) begin
      @(posedge clk); #1;
      start     = (i == sp_a) || (i == sp_b);
      rst_b     = (i == rst_cycle) ? 1'b0 : 1'b1;
      ctrl_bits = in_ctrl[i];
      cnt2      = in_cnt2[i];
      @(negedge clk);
      obs_c[i] = c; obs_busy[i] = busy; obs_done[i] = done;
    end
    start = 1'b0; rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b1; ctrl_bits = 3'b000; cnt2 = 3'd0; m7 = 1'b0; cnt1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (c !== 14'h0000) begin bad++; $display("FAIL reset_c cyc=%0d got=%h want=0000", k, c); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=0", k, busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done cyc=%0d got=%b want=0", k, done); end
    end
    rst_b = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({c, busy, done} !== 16'h0000) begin bad++; $display("FAIL reset_idle got c=%h busy=%b done=%b want idle", c, busy, done); end
  endtask

  task automatic test_nominal();
    int ndone, first;
    build_model(1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_trace(1'b0, 1'b1, 0, 0, 0);
    ndone = 0; first = 0;
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL nominal cyc=%0d got c=%h b=%b d=%b want c=%h b=%b d=%b", i,
                        obs_c[i], obs_busy[i], obs_done[i], exp_c[i], exp_busy[i], exp_done[i]);
      end
      if (obs_done[i] === 1'b1) begin ndone++; if (first == 0) first = i; end
    end
    total++; if (first != 24) begin bad++; $display("FAIL nominal_latency got=%0d want=24", first); end
    total++; if (ndone != 1) begin bad++; $display("FAIL nominal_done_count got=%0d want=1", ndone); end
  endtask

  task automatic test_digit_select();
    build_model(1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_trace(1'b1, 1'b0, 0, 0, 0);
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL digit cyc=%0d got c=%h want c=%h", i, obs_c[i], exp_c[i]);
      end
    end
    total++; if (obs_c[3] !== 14'h0020) begin bad++; $display("FAIL digit_010 got=%h want=0020", obs_c[3]); end
    total++; if (obs_c[5] !== 14'h0010) begin bad++; $display("FAIL digit_101 got=%h want=0010", obs_c[5]); end
    total++; if (obs_c[7] !== 14'h0008) begin bad++; $display("FAIL digit_111 got=%h want=0008", obs_c[7]); end
    total++; if (obs_c[9] !== 14'h0008) begin bad++; $display("FAIL digit_000 got=%h want=0008", obs_c[9]); end
  endtask

  task automatic test_correction();
    int first, nbad;
    build_model(1'b1, 1'b0, 1, 1'b1, 1'b0);
    run_trace(1'b1, 1'b0, 0, 0, 0);
    first = 0; nbad = 0;
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL correction cyc=%0d got c=%h d=%b want c=%h d=%b", i, obs_c[i], obs_done[i], exp_c[i], exp_done[i]);
      end
      if (obs_done[i] === 1'b1 && first == 0) first = i;
      if (obs_c[i] === 14'h0004 || obs_c[i] === 14'h0800) nbad++;
    end
    total++; if (obs_c[19] !== 14'h0240) begin bad++; $display("FAIL corr_word got=%h want=0240", obs_c[19]); end
    total++; if (obs_c[20] !== 14'h04C0) begin bad++; $display("FAIL corr_result got=%h want=04C0", obs_c[20]); end
    total++; if (first != 23) begin bad++; $display("FAIL corr_latency got=%0d want=23", first); end
    total++; if (nbad != 0) begin bad++; $display("FAIL corr_no_norm got=%0d want=0", nbad); end
  endtask

  task automatic test_random();
    logic rm7, rcnt1, rcorr;
    int first, want;
    for (int r = 0; r < 8; r++) begin
      rm7 = 1'($urandom); rcnt1 = 1'($urandom); rcorr = 1'($urandom);
      build_model(rm7, rcnt1, 1, rcorr, 1'b0);
      run_trace(rm7, rcnt1, 0, 0, 0);
      first = 0;
      for (int i = 1; i <= len; i++) begin
        total++;
        if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
          bad++; $display("FAIL random r=%0d cyc=%0d got c=%h b=%b d=%b want c=%h b=%b d=%b", r, i,
                          obs_c[i], obs_busy[i], obs_done[i], exp_c[i], exp_busy[i], exp_done[i]);
        end
        if (obs_done[i] === 1'b1 && first == 0) first = i;
      end
      want = 22 + int'(!rm7) + int'(rcnt1) + int'(rcorr);
      total++; if (first != want) begin bad++; $display("FAIL random_latency r=%0d got=%0d want=%0d", r, first, want); end
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    build_model(1'b1, 1'b1, 1, 1'b0, 1'b0);
    run_trace(1'b1, 1'b1, 4, done_idx, 0);
    ndone = 0;
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL start_ignored cyc=%0d got c=%h b=%b want c=%h b=%b", i, obs_c[i], obs_busy[i], exp_c[i], exp_busy[i]);
      end
      if (obs_done[i] === 1'b1) ndone++;
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL start_ignored_done got=%0d want=1", ndone); end
  endtask

  task automatic test_reset_midloop();
    build_model(1'b1, 1'b0, 1, 1'b0, 1'b0);
    len = 12;
    run_trace(1'b1, 1'b0, 0, 0, 11);
    total++; if (obs_c[11] !== exp_c[11]) begin bad++; $display("FAIL midloop_check got=%h want=%h", obs_c[11], exp_c[11]); end
    total++; if ({obs_c[12], obs_busy[12], obs_done[12]} !== 16'h0000) begin
      bad++; $display("FAIL midloop_reset got c=%h b=%b d=%b want idle", obs_c[12], obs_busy[12], obs_done[12]);
    end
    build_model(1'b0, 1'b0, 1, 1'b1, 1'b0);
    run_trace(1'b0, 1'b0, 0, 0, 0);
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL after_reset cyc=%0d got c=%h d=%b want c=%h d=%b", i, obs_c[i], obs_done[i], exp_c[i], exp_done[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    build_model(1'b1, 1'b0, 1, 1'b0, 1'b1);
    run_trace(1'b1, 1'b0, done_idx + 1, 0, 0);
    for (int i = 1; i <= len; i++) begin
      total++;
      if ({obs_c[i], obs_busy[i], obs_done[i]} !== {exp_c[i], exp_busy[i], exp_done[i]}) begin
        bad++; $display("FAIL back_to_back cyc=%0d got c=%h b=%b want c=%h b=%b", i, obs_c[i], obs_busy[i], exp_c[i], exp_busy[i]);
      end
    end
    @(posedge clk); #1; rst_b = 1'b0;
    @(posedge clk); #1; rst_b = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_cleanup got busy=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_digit_select();
    test_correction();
    test_random();
    test_start_ignored();
    test_reset_midloop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/srt2_control_unit.md
# srt2_control_unit

Sequencer for the 8-bit SRT radix-2 divider datapath. It drives the datapath's 14-bit control word `c` and consumes its status flags (`m7`, `cnt1`, `cnt2`, partial-remainder top bits). It runs load, normalise, eight quotient-digit iterations, optional correction, quotient assembly, denormalise and output, then pulses `done`. It sits between the ALU top-level opcode decode and the divider datapath.

## Interface
Parameters:
- `ITER`, 8, number of SRT iterations; fixed at 8 for this datapath.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state changes on rising edge
- `rst_b`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a division; sampled only in IDLE
- `ctrl_bits`  in  3  A[8:6] from datapath (partial-remainder sign/top bits)
- `m7`  in  1  M[7]; 1 means divisor already normalised
- `cnt1`  in  1  normalisation-performed flag from datapath
- `cnt2`  in  3  datapath iteration counter
- `c`  out  14  datapath control word; one state per cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in DONE

## Operation
- States and `c` value in each state:
  - IDLE: 0x0000.
  - LOAD1: c[0]; clears A, Q*, CNT2 and loads Q.
  - LOAD2: c[1]; loads M and computes leading zeros.
  - NORM: c[2].
  - CHECK: one of c[3], c[4], c[5].
  - COUNT: c[8].
  - CORRECT: c[6]|c[9] = 0x0240.
  - RESULT: c[6]|c[7]|c[10] = 0x04C0.
  - UNNORM: c[11].
  - OUT_Q: c[12].
  - OUT_A: c[13].
  - DONE: 0x0000, `done` = 1.
- Transitions:
  - IDLE goes to LOAD1 when `start` = 1.
  - LOAD1 goes to LOAD2.
  - LOAD2 goes to NORM if `m7` = 0, else to CHECK.
  - NORM goes to CHECK.
  - CHECK goes to COUNT.
  - COUNT goes to CHECK if `cnt2` != 7. If `cnt2` = 7, it goes to CORRECT when `ctrl_bits[2]` = 1, else to RESULT.
  - CORRECT goes to RESULT.
  - RESULT goes to UNNORM if `cnt1` = 1, else to OUT_Q.
  - UNNORM goes to OUT_Q.
  - OUT_Q goes to OUT_A.
  - OUT_A goes to DONE.
  - DONE goes to IDLE unconditionally.
- Quotient-digit select in CHECK (combinational on `ctrl_bits`; exactly one of c[5:3] set):
  - 000 or 111: q = 0, c[3] (shift only).
  - 001, 010, 011: q = +1, c[5] (set Q bit, subtract M).
  - 100, 101, 110: q = −1, c[4] (set Q* bit, add M).
- Iteration count comes solely from the datapath `cnt2`. `cnt2` is sampled in COUNT, before that state's increment takes effect, so the values seen are 0..7 and the loop runs exactly 8 times.
- `c` is Moore-decoded from the registered state and is glitch-free. No bit of `c` outside the current state's set is ever high.

## Timing
- Reset: on a rising edge with `rst_b` = 0, the state goes to IDLE and `c` = 0, `busy` = 0, `done` = 0 from that edge. This holds in every state, including mid-loop.
- `start` is sampled on the edge that leaves IDLE. The first cycle after that edge is LOAD1.
- `start` is ignored in every non-IDLE state, including DONE. There is no queuing.
- Latency from the `start` edge to the DONE cycle:
  - 22 cycles with `m7` = 1, no correction, `cnt1` = 0.
  - NORM adds 1 cycle.
  - UNNORM adds 1 cycle.
  - CORRECT adds 1 cycle.
  - Maximum is 25.
- `busy` rises in LOAD1 and falls on entry to IDLE. A back-to-back `start` is accepted 1 cycle after DONE.
- `ctrl_bits`, `cnt1` and `cnt2` are consumed in the cycle they are sampled. The datapath must present them stably within that cycle.

## Structure
- Shared package `srt2_pkg`, used by the datapath and its tests:
  - state enum;
  - localparams for every c-bit index (C_LOAD1 … C_OUT_A);
  - control-word constants (C_CORRECT = 0x0240, C_RESULT = 0x04C0);
  - `ITER`.
- Sub-module `srt2_qsel`: combinational `ctrl_bits` → 3-bit one-hot {c[5],c[4],c[3]}.
- The top level contains the state register, next-state logic and output decode.

## Test plan
- Reset: hold `rst_b` = 0 for 2 cycles with `start` = 1 → `c` = 0, `busy` = 0, `done` = 0, and the state stays IDLE.
- Nominal run: `m7` = 0, `cnt1` = 1, `ctrl_bits` = 000, bench `cnt2` model → `c` sequence is:
  - 0x0001, 0x0002, 0x0004;
  - then 0x0008/0x0100 alternating 8 times;
  - then 0x04C0, 0x0800, 0x1000, 0x2000, 0x0000.
  - `done` is high in cycle 24 only.
- Digit select: in CHECK, `ctrl_bits` = 010 → 0x0020; 101 → 0x0010; 111 → 0x0008; 000 → 0x0008.
- Correction, fastest path: `m7` = 1, `cnt1` = 0, `ctrl_bits[2]` = 1 at the final COUNT → 0x0240 before 0x04C0, no 0x0004, no 0x0800, `done` in cycle 23.
- Robustness:
  - `start` pulsed in COUNT and in DONE → ignored, a single `done`.
  - `rst_b` = 0 in the 5th CHECK → the next edge gives IDLE with `c` = 0; a fresh `start` then completes normally.
